// File: rtl/xcore_if_ibuf_pkg.sv
// Shared parameters for the instruction fetch buffer.
// Optional same-cycle bypass is enabled by defining XCORE_IBUF_BYPASS_EN.
package xcore_if_ibuf_pkg;

    localparam int WIDTH      = 32;
    localparam int IBUF_DEPTH = 4;

endpackage

// File: rtl/xcore_if_ibuf_sync_fifo.sv
// xcore_sync_fifo: generic circular FIFO with power-of-two depth and a
// synchronous clear; storage is not reset, pointers and count are.
module xcore_sync_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          i_sys_clk,
    input  logic          i_sys_rst,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic [AW:0]   cnt,
    output logic          full,
    output logic          empty
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == FULL_CNT);
    assign empty   = (cnt == '0);
    assign do_push = push && !full && !clr;
    assign do_pop  = pop && !empty && !clr;
    assign rdata   = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/xcore_if_ibuf.sv
// Instruction buffer between fetch and decode. Optional macro
// XCORE_IBUF_BYPASS_EN forwards an instruction straight to decode when empty.
module xcore_if_ibuf
    import xcore_if_ibuf_pkg::*;
#(
    parameter int DEPTH = IBUF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             i_sys_clk,
    input  logic             i_sys_rst,
    input  logic             i_pc_instr_valid,
    input  logic [WIDTH-1:0] i_pc_addr,
    input  logic [WIDTH-1:0] i_pc_instr,
    input  logic             i_pred_taken,
    input  logic             i_flush,
    input  logic             i_id_ready,
    output logic             o_if_stall,
    output logic             o_id_valid,
    output logic [WIDTH-1:0] o_id_pc,
    output logic [WIDTH-1:0] o_id_instr,
    output logic             o_id_pred_taken,
    output logic [AW:0]      o_ibuf_cnt,
    output logic             o_ibuf_ovf
);

    localparam int          EW        = 2*WIDTH + 1;
    localparam logic [AW:0] STALL_CNT = (AW+1)'(DEPTH - 1);

    logic [EW-1:0] wr_entry;
    logic [EW-1:0] head_entry;
    logic [AW:0]   fifo_cnt;
    logic          fifo_full;
    logic          fifo_empty;
    logic          bypass;
    logic          push;
    logic          pop;

    // Handshake: an entry moves to decode on a cycle where o_id_valid and
    // i_id_ready are both high and i_flush is low; o_id_* hold until then.
`ifdef XCORE_IBUF_BYPASS_EN
    assign bypass = i_sys_rst && fifo_empty && i_pc_instr_valid && i_id_ready && !i_flush;
`else
    assign bypass = 1'b0;
`endif

    assign wr_entry = {i_pc_addr, i_pc_instr, i_pred_taken};
    assign push     = i_pc_instr_valid && !i_flush && !bypass;
    assign pop      = !fifo_empty && i_id_ready && !i_flush;

    xcore_sync_fifo #(
        .DW    (EW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .i_sys_clk (i_sys_clk),
        .i_sys_rst (i_sys_rst),
        .clr       (i_flush),
        .push      (push),
        .pop       (pop),
        .wdata     (wr_entry),
        .rdata     (head_entry),
        .cnt       (fifo_cnt),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign o_id_valid = !fifo_empty || bypass;
    assign {o_id_pc, o_id_instr, o_id_pred_taken} = bypass ? wr_entry : head_entry;
    assign o_ibuf_cnt = fifo_cnt;
    // One slot stays free for the word already in flight from the PC stage.
    assign o_if_stall = (fifo_cnt >= STALL_CNT);

    // A word arriving while full is lost; the flag stays until reset.
    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            o_ibuf_ovf <= 1'b0;
        end else if (i_pc_instr_valid && fifo_full) begin
            o_ibuf_ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_xcore_if_ibuf.sv
// Bench for xcore_if_ibuf: directed vector table, reset/bypass sequences,
// then random traffic checked against a queue-based reference model.
module tb_xcore_if_ibuf;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred;
    logic        flush;
    logic        ready;
    logic        stall;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        id_pred;
    logic [2:0]  cnt;
    logic        ovf;

    int n_checks = 0;
    int n_pass   = 0;

    logic [64:0] exp_q[$];
    logic        m_ovf;

    xcore_if_ibuf dut (
        .i_sys_clk        (clk),
        .i_sys_rst        (rst_n),
        .i_pc_instr_valid (valid),
        .i_pc_addr        (pc),
        .i_pc_instr       (instr),
        .i_pred_taken     (pred),
        .i_flush          (flush),
        .i_id_ready       (ready),
        .o_if_stall       (stall),
        .o_id_valid       (id_valid),
        .o_id_pc          (id_pc),
        .o_id_instr       (id_instr),
        .o_id_pred_taken  (id_pred),
        .o_ibuf_cnt       (cnt),
        .o_ibuf_ovf       (ovf)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        pred;
        logic        flush;
        logic        ready;
        logic        chk_data;
        logic        e_valid;
        logic [2:0]  e_cnt;
        logic        e_stall;
        logic        e_ovf;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_pred;
    } vec_t;

    vec_t tbl[11];

    function automatic vec_t mk(logic v, logic [31:0] p, logic [31:0] ins, logic pr,
                                logic f, logic r, logic cd, logic ev, logic [2:0] ec,
                                logic es, logic eo, logic [31:0] ep, logic [31:0] ei,
                                logic epr);
        vec_t t;
        t.v = v; t.pc = p; t.instr = ins; t.pred = pr; t.flush = f; t.ready = r;
        t.chk_data = cd; t.e_valid = ev; t.e_cnt = ec; t.e_stall = es; t.e_ovf = eo;
        t.e_pc = ep; t.e_instr = ei; t.e_pred = epr;
        return t;
    endfunction

    // driver tasks
    task automatic drive(logic v, logic [31:0] p, logic [31:0] ins, logic pr,
                         logic f, logic r);
        valid = v; pc = p; instr = ins; pred = pr; flush = f; ready = r;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // scoreboard compare
    task automatic chk(string name, logic [64:0] act, logic [64:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chk_status(string tag, logic ev, logic [2:0] ec, logic es, logic eo);
        chk({tag, ".valid"}, id_valid, ev);
        chk({tag, ".cnt"},   cnt,      ec);
        chk({tag, ".stall"}, stall,    es);
        chk({tag, ".ovf"},   ovf,      eo);
    endtask

    initial begin
        logic [64:0] head;
        logic        bp;
        int          sz;

        idle();
        rst_n = 1'b0;
        m_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk_status("reset", 1'b0, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();

        tbl[0]  = mk(1, 32'h10,  32'h00A00093, 0, 0, 0, 1, 1, 3'd1, 0, 0, 32'h10,  32'h00A00093, 0);
        tbl[1]  = mk(1, 32'h14,  32'h10000014, 0, 0, 0, 1, 1, 3'd2, 0, 0, 32'h10,  32'h00A00093, 0);
        tbl[2]  = mk(1, 32'h18,  32'h10000018, 1, 0, 0, 1, 1, 3'd3, 1, 0, 32'h10,  32'h00A00093, 0);
        tbl[3]  = mk(1, 32'h1c,  32'h1000001c, 0, 0, 0, 1, 1, 3'd4, 1, 0, 32'h10,  32'h00A00093, 0);
        tbl[4]  = mk(1, 32'h20,  32'h10000020, 0, 0, 0, 1, 1, 3'd4, 1, 1, 32'h10,  32'h00A00093, 0);
        tbl[5]  = mk(0, 32'h0,   32'h0,        0, 0, 1, 1, 1, 3'd3, 1, 1, 32'h14,  32'h10000014, 0);
        tbl[6]  = mk(0, 32'h0,   32'h0,        0, 0, 1, 1, 1, 3'd2, 0, 1, 32'h18,  32'h10000018, 1);
        tbl[7]  = mk(1, 32'h24,  32'h10000024, 0, 0, 1, 1, 1, 3'd2, 0, 1, 32'h1c,  32'h1000001c, 0);
        tbl[8]  = mk(1, 32'h28,  32'h10000028, 0, 0, 0, 1, 1, 3'd3, 1, 1, 32'h1c,  32'h1000001c, 0);
        tbl[9]  = mk(1, 32'h2c,  32'h1000002c, 0, 1, 1, 0, 0, 3'd0, 0, 1, 32'h0,   32'h0,        0);
        tbl[10] = mk(1, 32'h100, 32'h00000013, 1, 0, 0, 1, 1, 3'd1, 0, 1, 32'h100, 32'h00000013, 1);

        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].v, tbl[i].pc, tbl[i].instr, tbl[i].pred, tbl[i].flush, tbl[i].ready);
            step();
            idle();
            #1;
            chk_status($sformatf("vec%0d", i), tbl[i].e_valid, tbl[i].e_cnt,
                       tbl[i].e_stall, tbl[i].e_ovf);
            if (tbl[i].chk_data)
                chk($sformatf("vec%0d.head", i), {id_pc, id_instr, id_pred},
                    {tbl[i].e_pc, tbl[i].e_instr, tbl[i].e_pred});
        end

        // async reset mid-stream at cnt=2 with ovf set
        drive(1, 32'h104, 32'h10000104, 0, 0, 0);
        step();
        idle();
        #1;
        chk_status("pre_rst", 1'b1, 3'd2, 1'b0, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_status("async_rst", 1'b0, 3'd0, 1'b0, 1'b0);
        #3;
        rst_n = 1'b1;
        step();
        chk_status("post_rst", 1'b0, 3'd0, 1'b0, 1'b0);

`ifdef XCORE_IBUF_BYPASS_EN
        drive(1, 32'h200, 32'h00000013, 0, 0, 1);
        #1;
        chk_status("bypass", 1'b1, 3'd0, 1'b0, 1'b0);
        chk("bypass.instr", id_instr, 32'h13);
        step();
        idle();
        #1;
        chk_status("bypass_after", 1'b0, 3'd0, 1'b0, 1'b0);
`endif

        // random traffic against the reference queue
        exp_q.delete();
        m_ovf = 1'b0;
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 3) != 0, $urandom, $urandom, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0);
            sz = exp_q.size();
`ifdef XCORE_IBUF_BYPASS_EN
            bp = (sz == 0) && valid && ready && !flush;
`else
            bp = 1'b0;
`endif
            @(negedge clk);
            chk_status($sformatf("rnd%0d", c), (sz != 0) || bp, 3'(sz),
                       sz >= DEPTH - 1, m_ovf);
            if (bp) chk($sformatf("rnd%0d.byp", c), {id_pc, id_instr, id_pred}, {pc, instr, pred});
            else if (sz != 0) begin
                head = exp_q[0];
                chk($sformatf("rnd%0d.head", c), {id_pc, id_instr, id_pred}, head);
            end
            if (valid && sz == DEPTH) m_ovf = 1'b1;
            if (flush) exp_q.delete();
            else if (!bp) begin
                if (ready && sz != 0) void'(exp_q.pop_front());
                if (valid && sz < DEPTH) exp_q.push_back({pc, instr, pred});
            end
            step();
        end

        // final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
